// File: rtl/spi_target.sv
// spi_target: SPI target (CPOL=0, MSB first) decoding 16-bit R/W register frames into a parallel bus.
module spi_target #(
  parameter int WORD_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  enable,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [WORD_WIDTH-2:0] o_addr,
  output logic [WORD_WIDTH-1:0] o_wr_data,
  output logic                  o_wr_strobe,
  output logic                  o_rd_req,
  input  logic [WORD_WIDTH-1:0] i_rd_data,
  output logic                  busy,
  output logic                  o_transaction_complete,
  output logic                  o_frame_error
);
  localparam int CW = $clog2(2 * WORD_WIDTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, mosi_sy;
  logic [SYNC_STAGES:0] vld;
  logic sclk_q, cs_q, armed, rd_ld, rw;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall, shift_en, last_a, last_d;
  logic [CW-1:0] bit_cnt;
  logic [WORD_WIDTH-2:0] sh;
  logic [WORD_WIDTH-1:0] tx;
  assign sclk_s    = sclk_sy[SYNC_STAGES-1];
  assign cs_s      = cs_sy[SYNC_STAGES-1];
  assign mosi_s    = mosi_sy[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  // armed only after CS is seen high once the chain holds real pin values, so a frame cut by reset is ignored
  assign cs_fall   = ~cs_s & cs_q & armed;
  assign shift_en  = sclk_rise & ~cs_s & (state == ADDR || state == DATA);
  assign last_a    = shift_en && state == ADDR && bit_cnt == CW'(WORD_WIDTH - 1);
  assign last_d    = shift_en && state == DATA && bit_cnt == CW'(2 * WORD_WIDTH - 1);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sclk_sy <= '0;
      cs_sy   <= '1;
      mosi_sy <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      vld     <= '0;
      armed   <= 1'b0;
    end else begin
      sclk_sy[0] <= SCLK;
      cs_sy[0]   <= CS;
      mosi_sy[0] <= MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sy[i] <= sclk_sy[i-1];
        cs_sy[i]   <= cs_sy[i-1];
        mosi_sy[i] <= mosi_sy[i-1];
      end
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
      vld    <= {vld[SYNC_STAGES-1:0], 1'b1};
      armed  <= armed | (vld[SYNC_STAGES] & cs_s);
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = (cs_fall && enable) ? ADDR : IDLE;
      ADDR: nxt = cs_rise ? IDLE : last_a ? DATA : ADDR;
      DATA: nxt = cs_rise ? IDLE : last_d ? DONE : DATA;
      DONE: nxt = cs_rise ? IDLE : DONE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bit_cnt                <= '0;
      sh                     <= '0;
      rw                     <= 1'b0;
      tx                     <= '0;
      rd_ld                  <= 1'b0;
      MISO                   <= 1'b0;
      o_addr                 <= '0;
      o_wr_data              <= '0;
      o_wr_strobe            <= 1'b0;
      o_rd_req               <= 1'b0;
      o_transaction_complete <= 1'b0;
      o_frame_error          <= 1'b0;
    end else begin
      o_rd_req               <= last_a & sh[WORD_WIDTH-2];
      o_wr_strobe            <= last_d & ~rw;
      o_frame_error          <= cs_rise & (state == ADDR || state == DATA);
      o_transaction_complete <= cs_rise & (state == DONE);
      rd_ld                  <= o_rd_req;
      bit_cnt <= (state == IDLE) ? '0 : shift_en ? bit_cnt + 1'b1 : bit_cnt;
      if (shift_en) sh <= {sh[WORD_WIDTH-3:0], mosi_s};
      if (last_a) begin
        rw     <= sh[WORD_WIDTH-2];
        o_addr <= {sh[WORD_WIDTH-3:0], mosi_s};
      end
      if (last_d && !rw) o_wr_data <= {sh, mosi_s};
      if (rd_ld) tx <= i_rd_data;
      else if (sclk_fall && state == DATA) tx <= tx << 1;
      MISO <= (state == DATA && rw) ? (sclk_fall ? tx[WORD_WIDTH-1] : MISO) : 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed frames against spi_target with hand-computed expectations.
module tb_spi_target;
  localparam int H = 6;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, SCLK = 1'b0, CS = 1'b1, MOSI = 1'b0;
  logic MISO, o_wr_strobe, o_rd_req, busy, o_transaction_complete, o_frame_error;
  logic [6:0] o_addr;
  logic [7:0] o_wr_data, i_rd_data = 8'h3C;
  int checks = 0, errors = 0;
  int nwr = 0, nrd = 0, ncomp = 0, nerr = 0, nbusy = 0, nmiso = 0;
  logic [6:0] rd_addr = '0;
  logic [15:0] mi;
  int w0, r0, c0, e0, b0, m0;
  always #5 clk = ~clk;
  spi_target dut (
    .i_clock(clk), .i_reset(rst), .enable(enable), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
    .MISO(MISO), .o_addr(o_addr), .o_wr_data(o_wr_data), .o_wr_strobe(o_wr_strobe),
    .o_rd_req(o_rd_req), .i_rd_data(i_rd_data), .busy(busy),
    .o_transaction_complete(o_transaction_complete), .o_frame_error(o_frame_error)
  );
  always @(negedge clk) begin
    nwr   <= nwr + int'(o_wr_strobe);
    nrd   <= nrd + int'(o_rd_req);
    ncomp <= ncomp + int'(o_transaction_complete);
    nerr  <= nerr + int'(o_frame_error);
    nbusy <= nbusy + int'(busy);
    nmiso <= nmiso + int'(MISO);
    if (o_rd_req) rd_addr <= o_addr;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    @(negedge clk);
    w0 = nwr; r0 = nrd; c0 = ncomp; e0 = nerr; b0 = nbusy; m0 = nmiso;
  endtask
  task automatic xfer(input logic [15:0] d, input int n, output logic [15:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = (i < 16) ? d[15-i] : 1'b0;
      repeat (H) @(negedge clk);
      SCLK = 1'b1;
      m = {m[14:0], MISO};
      repeat (H) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask
  task automatic cs_low();
    CS = 1'b0;
    repeat (H) @(negedge clk);
  endtask
  task automatic cs_high();
    repeat (H) @(negedge clk);
    CS = 1'b1;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_miso", MISO, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_wdata", o_wr_data, 0);
    // write 0x12,0xA5
    snap();
    cs_low();
    xfer(16'h12A5, 4, mi);
    chk("wr_busy_mid", busy, 1);
    xfer(16'h2A50, 12, mi);
    cs_high();
    chk("wr_addr", o_addr, 7'h12);
    chk("wr_data", o_wr_data, 8'hA5);
    chk("wr_strobes", nwr - w0, 1);
    chk("wr_rdreq", nrd - r0, 0);
    chk("wr_complete", ncomp - c0, 1);
    chk("wr_err", nerr - e0, 0);
    chk("wr_miso", nmiso - m0, 0);
    chk("wr_busy_end", busy, 0);
    // read 0x85 with rd_data 0x3C
    snap();
    cs_low();
    xfer(16'h8500, 16, mi);
    cs_high();
    chk("rd_req", nrd - r0, 1);
    chk("rd_addr", rd_addr, 7'h05);
    chk("rd_miso_hi", mi[15:8], 8'h00);
    chk("rd_miso_lo", mi[7:0], 8'h3C);
    chk("rd_strobes", nwr - w0, 0);
    chk("rd_complete", ncomp - c0, 1);
    // aborted write after 11 bits
    snap();
    cs_low();
    xfer(16'h33CC, 11, mi);
    cs_high();
    chk("ab_err", nerr - e0, 1);
    chk("ab_strobes", nwr - w0, 0);
    chk("ab_complete", ncomp - c0, 0);
    chk("ab_busy", busy, 0);
    // enable low for a whole write frame
    enable = 1'b0;
    snap();
    cs_low();
    xfer(16'h44AA, 16, mi);
    cs_high();
    enable = 1'b1;
    chk("en_busy", nbusy - b0, 0);
    chk("en_strobes", nwr - w0 + nrd - r0 + ncomp - c0 + nerr - e0, 0);
    chk("en_miso", nmiso - m0, 0);
    // reset at bit 5, released with CS low, frame finished afterwards
    snap();
    cs_low();
    xfer(16'h5AC3, 5, mi);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    xfer(16'hAC3 << 5, 11, mi);
    cs_high();
    chk("rs_strobes", nwr - w0, 0);
    chk("rs_err", nerr - e0, 0);
    chk("rs_complete", ncomp - c0, 0);
    snap();
    cs_low();
    xfer(16'h01FF, 16, mi);
    cs_high();
    chk("rs_next_addr", o_addr, 7'h01);
    chk("rs_next_data", o_wr_data, 8'hFF);
    chk("rs_next_strobes", nwr - w0, 1);
    // write 0x7F,0x00 with 18 pulses, enable dropped mid-frame
    snap();
    cs_low();
    xfer(16'h7F00, 1, mi);
    enable = 1'b0;
    xfer(16'hFE00, 15, mi);
    repeat (H) @(negedge clk);
    chk("x_strobe_at16", nwr - w0, 1);
    xfer(16'hFFFF, 2, mi);
    cs_high();
    enable = 1'b1;
    chk("x_strobes", nwr - w0, 1);
    chk("x_addr", o_addr, 7'h7F);
    chk("x_data", o_wr_data, 8'h00);
    chk("x_complete", ncomp - c0, 1);
    chk("x_err", nerr - e0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bits per frame byte; frame = 2*WORD_WIDTH bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on SCLK/CS/MOSI.
REQ-003 i_clock  in  1  system clock; all logic on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  permits IDLE->ADDR; ignored mid-frame.
REQ-006 SCLK  in  1  SPI clock from master; CPOL=0.
REQ-007 CS  in  1  chip select from master; active low.
REQ-008 MOSI  in  1  serial data from master, MSB first.
REQ-009 MISO  out  1  serial data to master, MSB first, registered.
REQ-010 o_addr  out  WORD_WIDTH-1  register address (upper byte bits [6:0]).
REQ-011 o_wr_data  out  WORD_WIDTH  lower byte of a write frame.
REQ-012 o_wr_strobe  out  1  one-cycle pulse, write frame accepted.
REQ-013 o_rd_req  out  1  one-cycle pulse, read data wanted for o_addr.
REQ-014 i_rd_data  in  WORD_WIDTH  read data, valid the cycle after o_rd_req.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 o_transaction_complete  out  1  one-cycle pulse at end of a good frame.
REQ-017 o_frame_error  out  1  one-cycle pulse when CS rises before 16 bits.

Function
REQ-018 SHALL pass SCLK, CS, MOSI through SYNC_STAGES flops, then 1 edge-detect flop; MOSI delayed identically to SCLK.
REQ-019 SHALL require SCLK high and low phases each >= 4 i_clock cycles; faster SCLK is unsupported.
REQ-020 States: IDLE, ADDR, DATA, DONE.
REQ-021 IDLE->ADDR on detected CS falling edge with enable=1; bit counter cleared, MISO=0.
REQ-022 SHALL sample synced MOSI on each detected SCLK rising edge while CS low; rising edges with CS high ignored.
REQ-023 ADDR: after 8th rising edge, bit7 = R/W (1=read, 0=write), o_addr <= bits[6:0], ->DATA.
REQ-024 Read: o_rd_req pulses the cycle after the 8th bit is captured; i_rd_data loaded into tx shift register the following cycle.
REQ-025 Read: MISO <= rd_data[7] on the detected falling edge after the 8th rising edge, next bit on each later falling edge; MISO = 0 throughout ADDR and for write frames.
REQ-026 DATA: after 16th rising edge ->DONE; if write, o_wr_data <= lower byte and o_wr_strobe pulses the same cycle o_wr_data updates.
REQ-027 DONE: extra SCLK edges ignored, MISO=0; detected CS rising ->IDLE with o_transaction_complete pulse.
REQ-028 CS rising in ADDR or DATA ->IDLE with o_frame_error pulse; no o_wr_strobe; o_rd_req already issued is not retracted.
REQ-029 CS falling and SCLK rising detected in the same cycle: CS edge wins; SCLK edge not sampled.
REQ-030 enable falling mid-frame SHALL NOT abort the frame.
REQ-031 At most one o_wr_strobe and one o_rd_req per frame.

Reset
REQ-032 i_reset SHALL force IDLE, bit counter 0, MISO 0, o_addr 0, o_wr_data 0, all pulses 0, busy 0, synchronizers to CS=1/SCLK=0/MOSI=0.
REQ-033 After reset, a frame starts only on a fresh detected CS falling edge; a frame in progress at reset is ignored without o_frame_error.

Verification
REQ-034 Write frame 0x12,0xA5 -> o_addr=0x12, o_wr_data=0xA5, one o_wr_strobe, no o_rd_req, one o_transaction_complete after CS high.
REQ-035 Read frame 0x85, i_rd_data=0x3C -> one o_rd_req with o_addr=0x05; MISO on lower-byte rising edges = 0,0,1,1,1,1,0,0; no o_wr_strobe.
REQ-036 Write frame, CS high after 11 bits -> one o_frame_error, no o_wr_strobe, no o_transaction_complete, busy 0.
REQ-037 enable=0 for whole write frame -> busy, strobes, MISO all stay 0.
REQ-038 i_reset at bit 5 of a write frame, released with CS low -> no strobe or error; next clean frame 0x01,0xFF -> o_wr_data=0xFF.
REQ-039 Write frame 0x7F,0x00 with 18 SCLK pulses -> single o_wr_strobe at bit 16, o_addr=0x7F, o_wr_data=0x00.
